// File: rtl/bram_arbiter.sv
// Round-robin arbiter that shares one BRAM between two requesters, A and B.
// It issues at most one read or write per cycle and routes each read's data back to its issuer.
module bram_arbiter #(
    parameter int unsigned width = 4,
    parameter int unsigned depth = 1024,
    localparam int unsigned AW = $clog2(depth - 1)
) (
    input  logic             CLK,
    input  logic             nRST,

    input  logic             reqA__ENA,
    input  logic             reqA__write,
    input  logic [AW-1:0]    reqA__addr,
    input  logic [width-1:0] reqA__data,
    output logic             reqA__RDY,
    output logic             rspA__ENA,
    output logic [width-1:0] rspA__data,

    input  logic             reqB__ENA,
    input  logic             reqB__write,
    input  logic [AW-1:0]    reqB__addr,
    input  logic [width-1:0] reqB__data,
    output logic             reqB__RDY,
    output logic             rspB__ENA,
    output logic [width-1:0] rspB__data,

    output logic             write__ENA,
    output logic [AW-1:0]    write__addr,
    output logic [width-1:0] write__data,
    output logic             read__ENA,
    output logic [AW-1:0]    read__addr,
    input  logic [width-1:0] dataOut,
    input  logic             dataOut__RDY
);

    logic       started_q;
    logic       prio_q, prio_d;
    logic [1:0] pend_owner_q, pend_owner_d;

    logic             grant_a, grant_b, granted;
    logic             sel_write;
    logic [AW-1:0]    sel_addr;
    logic [width-1:0] sel_data;
    logic             rsp_fire;

    // Grants are held off for the first cycle after reset, while BRAM writes are still ignored.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            started_q    <= 1'b0;
            prio_q       <= 1'b0;
            pend_owner_q <= 2'b00;
        end else begin
            started_q    <= 1'b1;
            prio_q       <= prio_d;
            pend_owner_q <= pend_owner_d;
        end
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (started_q) begin
            if (reqA__ENA && reqB__ENA) begin
                grant_a = ~prio_q;
                grant_b = prio_q;
            end else begin
                grant_a = reqA__ENA;
                grant_b = reqB__ENA;
            end
        end
        granted = grant_a | grant_b;
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        if (grant_a) begin
            sel_write = reqA__write;
            sel_addr  = reqA__addr;
            sel_data  = reqA__data;
        end else if (grant_b) begin
            sel_write = reqB__write;
            sel_addr  = reqB__addr;
            sel_data  = reqB__data;
        end
    end

    always_comb begin
        reqA__RDY   = grant_a;
        reqB__RDY   = grant_b;
        write__ENA  = granted & sel_write;
        write__addr = '0;
        write__data = '0;
        read__ENA   = granted & ~sel_write;
        read__addr  = '0;
        if (write__ENA) begin
            write__addr = sel_addr;
            write__data = sel_data;
        end
        if (read__ENA) begin
            read__addr = sel_addr;
        end
    end

    // The loser of this cycle's grant is favoured next; idle cycles keep the current order.
    always_comb begin
        prio_d       = prio_q;
        pend_owner_d = 2'b00;
        if (granted) begin
            prio_d = grant_a;
        end
        if (read__ENA) begin
            pend_owner_d = {grant_b, 1'b1};
        end
    end

    // A pending read with no BRAM data strobe is dropped, not retried.
    always_comb begin
        rsp_fire   = pend_owner_q[0] & dataOut__RDY;
        rspA__ENA  = rsp_fire & ~pend_owner_q[1];
        rspB__ENA  = rsp_fire & pend_owner_q[1];
        rspA__data = rspA__ENA ? dataOut : '0;
        rspB__data = rspB__ENA ? dataOut : '0;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: behavioural BRAM, reference memory and priority model,
// and a response scoreboard filled at request acceptance and drained at each response.
module tb_bram_arbiter;

    localparam int unsigned W  = 4;
    localparam int unsigned AW = 10;

    typedef struct packed {
        logic         owner;
        logic [W-1:0] data;
    } exp_t;

    logic CLK, nRST;
    logic a_ena, a_write, b_ena, b_write;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_data, b_data;
    logic a_rdy, b_rdy, rsp_a_ena, rsp_b_ena;
    logic [W-1:0] rsp_a_data, rsp_b_data;
    logic w_ena, r_ena;
    logic [AW-1:0] w_addr, r_addr;
    logic [W-1:0]  w_data, dout;
    logic dout_rdy;

    int checks = 0;
    int errors = 0;
    logic   m_prio;
    logic [W-1:0] ref_mem [0:1023];
    exp_t   exp_q[$];
    exp_t   exp;

    logic [W-1:0] bram_mem [0:1023];
    logic bram_started, bram_drop;

    bram_arbiter #(.width(W), .depth(1024)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .reqA__ENA    (a_ena),
        .reqA__write  (a_write),
        .reqA__addr   (a_addr),
        .reqA__data   (a_data),
        .reqA__RDY    (a_rdy),
        .rspA__ENA    (rsp_a_ena),
        .rspA__data   (rsp_a_data),
        .reqB__ENA    (b_ena),
        .reqB__write  (b_write),
        .reqB__addr   (b_addr),
        .reqB__data   (b_data),
        .reqB__RDY    (b_rdy),
        .rspB__ENA    (rsp_b_ena),
        .rspB__data   (rsp_b_data),
        .write__ENA   (w_ena),
        .write__addr  (w_addr),
        .write__data  (w_data),
        .read__ENA    (r_ena),
        .read__addr   (r_addr),
        .dataOut      (dout),
        .dataOut__RDY (dout_rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // BRAM model: registered read, writes ignored on the first edge after reset release.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) bram_started <= 1'b0;
        else       bram_started <= 1'b1;
    end

    always @(posedge CLK) begin
        if (w_ena && bram_started) bram_mem[w_addr] <= w_data;
        if (r_ena) dout <= bram_mem[r_addr];
        dout_rdy <= r_ena & ~bram_drop;
    end

    task automatic write_word(input logic owner, input logic [AW-1:0] addr, input logic [W-1:0] data);
        @(negedge CLK);
        a_ena = ~owner; a_write = 1'b1; a_addr = addr; a_data = data;
        b_ena = owner;  b_write = 1'b1; b_addr = addr; b_data = data;
        ref_mem[addr] = data;
        m_prio = ~owner;
        @(negedge CLK);
        a_ena = 1'b0; b_ena = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        a_ena = 1'b1; a_write = 1'b1; a_addr = 10'd5; a_data = 4'h9;
        b_ena = 1'b0; b_write = 1'b0; b_addr = '0; b_data = '0;
        bram_drop = 1'b0;
        m_prio = 1'b0;
        #1;
        checks++;
        if ({a_rdy, b_rdy, w_ena, r_ena, rsp_a_ena, rsp_b_ena, w_addr, w_data, r_addr,
             rsp_a_data, rsp_b_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b%b w=%b r=%b rsp=%b%b want all 0",
                     a_rdy, b_rdy, w_ena, r_ena, rsp_a_ena, rsp_b_ena);
        end
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if ({a_rdy, w_ena, r_ena, rsp_a_ena, rsp_b_ena} !== '0) begin
            errors++;
            $display("FAIL reset_held got rdy=%b w=%b r=%b want 0", a_rdy, w_ena, r_ena);
        end
    endtask

    task automatic test_startup;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++;
        if ({a_rdy, w_ena} !== 2'b00) begin
            errors++;
            $display("FAIL startup_block got rdy=%b w=%b want 0 0", a_rdy, w_ena);
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({a_rdy, b_rdy, w_ena, r_ena, w_addr, w_data} !== {4'b1010, 10'd5, 4'h9}) begin
            errors++;
            $display("FAIL startup_write got rdy=%b w=%b r=%b addr=%0d data=%0h want rdy=1 w=1 addr=5 data=9",
                     a_rdy, w_ena, r_ena, w_addr, w_data);
        end
        ref_mem[5] = 4'h9;
        m_prio = 1'b1;
        @(negedge CLK);
        a_ena = 1'b0;
        #1;
        checks++;
        if (w_ena !== 1'b0) begin
            errors++;
            $display("FAIL startup_one_pulse got w=%b want 0", w_ena);
        end
    endtask

    task automatic test_single_read;
        @(negedge CLK);
        a_ena = 1'b1; a_write = 1'b0; a_addr = 10'd5;
        #1;
        checks++;
        if ({a_rdy, b_rdy, r_ena, w_ena, r_addr} !== {4'b1010, 10'd5}) begin
            errors++;
            $display("FAIL single_issue got rdy=%b%b r=%b w=%b addr=%0d want 10 1 0 5",
                     a_rdy, b_rdy, r_ena, w_ena, r_addr);
        end
        exp_q.push_back('{owner: 1'b0, data: ref_mem[5]});
        m_prio = 1'b1;
        @(negedge CLK);
        a_ena = 1'b0;
        #1;
        checks++;
        exp = exp_q.pop_front();
        if ({rsp_a_ena, rsp_a_data, rsp_b_ena, rsp_b_data} !== {1'b1, exp.data, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL single_rsp got A=%b/%0h B=%b/%0h want A=1/%0h B=0/0",
                     rsp_a_ena, rsp_a_data, rsp_b_ena, rsp_b_data, exp.data);
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({rsp_a_ena, rsp_b_ena} !== 2'b00) begin
            errors++;
            $display("FAIL single_rsp_once got %b%b want 00", rsp_a_ena, rsp_b_ena);
        end
    endtask

    task automatic test_contention;
        logic [1:0] want_rdy;
        write_word(1'b0, 10'd1, 4'h3);
        write_word(1'b1, 10'd2, 4'hC);
        for (int i = 0; i <= 4; i++) begin
            @(negedge CLK);
            a_ena = (i < 4); a_write = 1'b0; a_addr = 10'd1;
            b_ena = (i < 4); b_write = 1'b0; b_addr = 10'd2;
            #1;
            if (i > 0) begin
                checks++;
                exp = exp_q.pop_front();
                if ({rsp_a_ena, rsp_a_data, rsp_b_ena, rsp_b_data} !==
                    (exp.owner ? {5'b0, 1'b1, exp.data} : {1'b1, exp.data, 5'b0})) begin
                    errors++;
                    $display("FAIL contend_rsp[%0d] got A=%b/%0h B=%b/%0h want owner=%0d data=%0h",
                             i, rsp_a_ena, rsp_a_data, rsp_b_ena, rsp_b_data, exp.owner, exp.data);
                end
            end
            if (i < 4) begin
                want_rdy = m_prio ? 2'b01 : 2'b10;
                checks++;
                if ({a_rdy, b_rdy, r_ena, r_addr} !== {want_rdy, 1'b1, m_prio ? 10'd2 : 10'd1}) begin
                    errors++;
                    $display("FAIL contend_grant[%0d] got rdy=%b%b r=%b addr=%0d want rdy=%b",
                             i, a_rdy, b_rdy, r_ena, r_addr, want_rdy);
                end
                exp_q.push_back('{owner: m_prio, data: ref_mem[m_prio ? 2 : 1]});
                m_prio = ~m_prio;
            end
        end
    endtask

    task automatic test_write_then_read;
        @(negedge CLK);
        b_ena = 1'b1; b_write = 1'b1; b_addr = 10'd10; b_data = 4'h7;
        #1;
        checks++;
        if ({b_rdy, w_ena, r_ena, w_addr, w_data} !== {3'b110, 10'd10, 4'h7}) begin
            errors++;
            $display("FAIL wtr_write got rdy=%b w=%b r=%b addr=%0d data=%0h want 1 1 0 10 7",
                     b_rdy, w_ena, r_ena, w_addr, w_data);
        end
        ref_mem[10] = 4'h7;
        m_prio = 1'b0;
        @(negedge CLK);
        b_ena = 1'b0;
        a_ena = 1'b1; a_write = 1'b0; a_addr = 10'd10;
        #1;
        checks++;
        if ({a_rdy, r_ena, w_ena} !== 3'b110) begin
            errors++;
            $display("FAIL wtr_read got rdy=%b r=%b w=%b want 1 1 0", a_rdy, r_ena, w_ena);
        end
        exp_q.push_back('{owner: 1'b0, data: ref_mem[10]});
        m_prio = 1'b1;
        @(negedge CLK);
        a_ena = 1'b0;
        #1;
        checks++;
        exp = exp_q.pop_front();
        if ({rsp_a_ena, rsp_a_data, rsp_b_ena} !== {1'b1, exp.data, 1'b0}) begin
            errors++;
            $display("FAIL wtr_rsp got A=%b/%0h B=%b want A=1/%0h",
                     rsp_a_ena, rsp_a_data, rsp_b_ena, exp.data);
        end
    endtask

    task automatic test_mismatch;
        @(negedge CLK);
        a_ena = 1'b1; a_write = 1'b0; a_addr = 10'd1;
        bram_drop = 1'b1;
        m_prio = 1'b1;
        @(negedge CLK);
        bram_drop = 1'b0;
        a_ena = 1'b0;
        b_ena = 1'b1; b_write = 1'b0; b_addr = 10'd2;
        #1;
        checks++;
        if ({rsp_a_ena, rsp_b_ena, rsp_a_data} !== '0) begin
            errors++;
            $display("FAIL mismatch_drop got A=%b/%0h B=%b want no response",
                     rsp_a_ena, rsp_a_data, rsp_b_ena);
        end
        exp_q.push_back('{owner: 1'b1, data: ref_mem[2]});
        m_prio = 1'b0;
        @(negedge CLK);
        b_ena = 1'b0;
        #1;
        checks++;
        exp = exp_q.pop_front();
        if ({rsp_a_ena, rsp_b_ena, rsp_b_data} !== {2'b01, exp.data}) begin
            errors++;
            $display("FAIL mismatch_next got A=%b B=%b/%0h want A=0 B=1/%0h",
                     rsp_a_ena, rsp_b_ena, rsp_b_data, exp.data);
        end
    endtask

    task automatic test_reset_mid_read;
        @(negedge CLK);
        a_ena = 1'b1; a_write = 1'b0; a_addr = 10'd5;
        #1;
        checks++;
        if (a_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_accept got rdy=%b want 1", a_rdy);
        end
        #2;
        nRST = 1'b0;
        m_prio = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({a_rdy, b_rdy, r_ena} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_async got rdy=%b r=%b want 0 0", a_rdy, r_ena);
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({rsp_a_ena, rsp_b_ena} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_no_rsp got %b%b want 00", rsp_a_ena, rsp_b_ena);
        end
        @(negedge CLK);
        nRST = 1'b1;
        b_ena = 1'b1; b_write = 1'b0; b_addr = 10'd2;
        #1;
        checks++;
        if ({a_rdy, b_rdy, rsp_a_ena, rsp_b_ena} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_restart got rdy=%b%b rsp=%b%b want 0000",
                     a_rdy, b_rdy, rsp_a_ena, rsp_b_ena);
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_prio got rdy=%b%b want 10", a_rdy, b_rdy);
        end
        exp_q.push_back('{owner: 1'b0, data: ref_mem[5]});
        m_prio = 1'b1;
        @(negedge CLK);
        a_ena = 1'b0; b_ena = 1'b0;
        #1;
        checks++;
        exp = exp_q.pop_front();
        if ({rsp_a_ena, rsp_a_data, rsp_b_ena} !== {1'b1, exp.data, 1'b0}) begin
            errors++;
            $display("FAIL midreset_rsp got A=%b/%0h B=%b want A=1/%0h",
                     rsp_a_ena, rsp_a_data, rsp_b_ena, exp.data);
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            #1;
            checks++;
            if ({w_ena, r_ena, rsp_a_ena, rsp_b_ena, w_addr, w_data, r_addr} !== '0) begin
                errors++;
                $display("FAIL idle[%0d] got w=%b r=%b rsp=%b%b want all 0",
                         i, w_ena, r_ena, rsp_a_ena, rsp_b_ena);
            end
        end
        @(negedge CLK);
        a_ena = 1'b1; a_write = 1'b0; a_addr = 10'd1;
        b_ena = 1'b1; b_write = 1'b0; b_addr = 10'd2;
        #1;
        checks++;
        if ({a_rdy, b_rdy} !== (m_prio ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL idle_prio got rdy=%b%b want prio=%0d kept", a_rdy, b_rdy, m_prio);
        end
        exp_q.push_back('{owner: m_prio, data: ref_mem[m_prio ? 2 : 1]});
        m_prio = ~m_prio;
        @(negedge CLK);
        a_ena = 1'b0; b_ena = 1'b0;
        #1;
        checks++;
        exp = exp_q.pop_front();
        if ({rsp_a_ena, rsp_a_data, rsp_b_ena, rsp_b_data} !==
            (exp.owner ? {5'b0, 1'b1, exp.data} : {1'b1, exp.data, 5'b0})) begin
            errors++;
            $display("FAIL idle_rsp got A=%b/%0h B=%b/%0h want owner=%0d data=%0h",
                     rsp_a_ena, rsp_a_data, rsp_b_ena, rsp_b_data, exp.owner, exp.data);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_single_read();
        test_contention();
        test_write_then_read();
        test_mismatch();
        test_reset_mid_read();
        test_idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
